// File: rtl/accel_cfg_pkg.sv
// Shared register map, CHECK constant and STATUS bit layout for the
// accelerator configuration bank.
package accel_cfg_pkg;

   localparam logic [4:0] OFF_START  = 5'h10;
   localparam logic [4:0] OFF_STATUS = 5'h11;
   localparam logic [4:0] OFF_TIME   = 5'h12;
   localparam logic [4:0] OFF_CLEAR  = 5'h13;
   localparam logic [4:0] OFF_IRQ_EN = 5'h14;
   localparam logic [4:0] OFF_CHECK  = 5'h1F;

   localparam logic [31:0] CHECK_VALUE = 32'hF0F0F0F0;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;
   localparam int STATUS_ERR_BIT  = 2;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_BUSY = 1'b1
   } ch_state_e;

endpackage

// File: rtl/cfg_channel.sv
// One accelerator channel: parameter registers, start/done handshake FSM,
// sticky done/err flags, interrupt enable and saturating run timer.
//
//   state   | meaning
//   CH_IDLE | core not running; PARAM writes and START accepted
//   CH_BUSY | core running; TIME counts, PARAM/START writes flag err
module cfg_channel
   import accel_cfg_pkg::*;
#(
   parameter int DW = 32,
   parameter int NP = 4,
   parameter int TW = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NP-1:0]      param_we_i,
   input  logic               start_we_i,
   input  logic               clear_we_i,
   input  logic               irq_en_we_i,
   input  logic [DW-1:0]      wdata_i,
   input  logic               core_done_i,
   output logic [NP*DW-1:0]   params_o,
   output logic               core_start_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic               irq_en_o,
   output logic [TW-1:0]      time_o
);

   ch_state_e                state_q;
   logic [NP-1:0][DW-1:0]    params_q;
   logic                     core_start_q;
   logic                     done_q;
   logic                     err_q;
   logic                     irq_en_q;
   logic [TW-1:0]            time_q;

   logic start_req;
   logic param_req;
   logic set_done;
   logic set_err;

   assign start_req = start_we_i & wdata_i[0];
   assign param_req = |param_we_i;
   assign set_done  = (state_q == CH_BUSY) & core_done_i;
   assign set_err   = (state_q == CH_BUSY) & (start_req | param_req);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CH_IDLE;
         params_q     <= '0;
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         irq_en_q     <= 1'b0;
         time_q       <= '0;
      end else begin
         core_start_q <= 1'b0;
         case (state_q)
            CH_IDLE: begin
               for (int p = 0; p < NP; p++) begin
                  if (param_we_i[p]) params_q[p] <= wdata_i;
               end
               if (start_req) begin
                  state_q      <= CH_BUSY;
                  core_start_q <= 1'b1;
                  time_q       <= '0;
               end
            end
            CH_BUSY: begin
               // TIME spans core_start cycle up to, not including, the done cycle
               if (core_done_i) state_q <= CH_IDLE;
               else if (time_q != '1) time_q <= time_q + 1'b1;
            end
            default: state_q <= CH_IDLE;
         endcase
         done_q <= (done_q & ~(clear_we_i & wdata_i[0])) | set_done;
         err_q  <= (err_q  & ~(clear_we_i & wdata_i[1])) | set_err;
         if (irq_en_we_i) irq_en_q <= wdata_i[0];
      end
   end

   assign params_o     = params_q;
   assign core_start_o = core_start_q;
   assign busy_o       = (state_q == CH_BUSY);
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign irq_en_o     = irq_en_q;
   assign time_o       = time_q;

endmodule

// File: rtl/accel_config_bank.sv
// Configuration bank for NCH accelerator channels: address decode to the
// per-channel blocks, registered read mux and the shared interrupt.
module accel_config_bank
   import accel_cfg_pkg::*;
#(
   parameter int AW  = 12,
   parameter int DW  = 32,
   parameter int CW  = 8,
   parameter int NCH = 4,
   parameter int NP  = 4,
   parameter int TW  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  config_ena,
   input  logic                  config_wr,
   input  logic [CW-1:0]         config_addr,
   input  logic [DW-1:0]         config_wdata,
   output logic [DW-1:0]         config_rdata,
   output logic                  config_rvalid,
   output logic [NCH*NP*DW-1:0]  param_flat,
   output logic [NCH-1:0]        core_start,
   input  logic [NCH-1:0]        core_done,
   output logic [NCH-1:0]        busy,
   output logic                  irq
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int RW  = CW - CHW;

   if (CW < CHW + 5) begin : g_bad_cw
      $error("CW too narrow for channel field plus 5-bit register field");
   end
   if (NP < 1 || NP > 16) begin : g_bad_np
      $error("NP must be 1..16");
   end
   if (TW > DW || AW < 1) begin : g_bad_tw
      $error("TW must not exceed DW and AW must be positive");
   end

   logic [CHW-1:0]      ch_sel;
   logic [RW-1:0]       reg_sel;
   logic                ch_ok;
   logic                wr_en;
   logic                rd_en;

   logic [NP*DW-1:0]    ch_params [NCH];
   logic [TW-1:0]       ch_time   [NCH];
   logic [NCH-1:0]      ch_done;
   logic [NCH-1:0]      ch_err;
   logic [NCH-1:0]      ch_ien;

   logic [DW-1:0]       rdata_d;
   logic [DW-1:0]       rdata_q;
   logic                rvalid_q;
   logic                irq_q;

   assign ch_sel  = config_addr[CW-1 -: CHW];
   assign reg_sel = config_addr[RW-1:0];
   assign ch_ok   = ({1'b0, ch_sel} < (CHW+1)'(NCH));
   assign wr_en   = config_ena & config_wr;
   assign rd_en   = config_ena & ~config_wr;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic          sel_wr;
      logic [NP-1:0] param_we;

      assign sel_wr = wr_en & ch_ok & (ch_sel == CHW'(c));
      for (genvar p = 0; p < NP; p++) begin : g_pwe
         assign param_we[p] = sel_wr & (reg_sel == RW'(p));
      end

      cfg_channel #(
         .DW (DW),
         .NP (NP),
         .TW (TW)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .param_we_i   (param_we),
         .start_we_i   (sel_wr & (reg_sel == RW'(OFF_START))),
         .clear_we_i   (sel_wr & (reg_sel == RW'(OFF_CLEAR))),
         .irq_en_we_i  (sel_wr & (reg_sel == RW'(OFF_IRQ_EN))),
         .wdata_i      (config_wdata),
         .core_done_i  (core_done[c]),
         .params_o     (ch_params[c]),
         .core_start_o (core_start[c]),
         .busy_o       (busy[c]),
         .done_o       (ch_done[c]),
         .err_o        (ch_err[c]),
         .irq_en_o     (ch_ien[c]),
         .time_o       (ch_time[c])
      );

      assign param_flat[c*NP*DW +: NP*DW] = ch_params[c];
   end

   // CHECK decodes on the register field alone so it answers for any channel
   always_comb begin
      rdata_d = '0;
      if (reg_sel == RW'(OFF_CHECK)) begin
         rdata_d = DW'(CHECK_VALUE);
      end else if (ch_ok) begin
         if (reg_sel < RW'(NP)) begin
            rdata_d = ch_params[ch_sel][int'(reg_sel)*DW +: DW];
         end else begin
            case (reg_sel)
               RW'(OFF_STATUS): begin
                  rdata_d[STATUS_BUSY_BIT] = busy[ch_sel];
                  rdata_d[STATUS_DONE_BIT] = ch_done[ch_sel];
                  rdata_d[STATUS_ERR_BIT]  = ch_err[ch_sel];
               end
               RW'(OFF_TIME):   rdata_d = DW'(ch_time[ch_sel]);
               RW'(OFF_IRQ_EN): rdata_d[0] = ch_ien[ch_sel];
               default:         rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         rvalid_q <= rd_en;
         if (rd_en) rdata_q <= rdata_d;
         irq_q <= |(ch_done & ch_ien);
      end
   end

   assign config_rdata  = rdata_q;
   assign config_rvalid = rvalid_q;
   assign irq           = irq_q;

endmodule

// File: doc/accel_config_bank.md
ACCEL_CONFIG_BANK -- requirements
Module: accel_config_bank

Interface
REQ-001 SHALL have parameter AW, default 12: internal memory address width.
REQ-002 SHALL have parameter DW, default 32: data/register width.
REQ-003 SHALL have parameter CW, default 8: config address width; CW >= CHW+5, where CHW = max(1, clog2(NCH)).
REQ-004 SHALL have parameter NCH, default 4: number of independent accelerator channels.
REQ-005 SHALL have parameter NP, default 4: parameter registers per channel, 1..16.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port config_ena, input, 1: config access strobe.
REQ-009 SHALL have port config_wr, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port config_addr, input, CW: address; {channel field [CW-1:CW-CHW], register field [CW-CHW-1:0]}.
REQ-011 SHALL have port config_wdata, input, DW: write data.
REQ-012 SHALL have port config_rdata, output, DW: read data.
REQ-013 SHALL have port config_rvalid, output, 1: one-cycle read-data-valid.
REQ-014 SHALL have port param_flat, output, NCH*NP*DW: all parameter registers; channel c, param p at bits [(c*NP+p)*DW +: DW].
REQ-015 SHALL have port core_start, output, NCH: per-channel one-cycle start pulse.
REQ-016 SHALL have port core_done, input, NCH: per-channel completion pulse.
REQ-017 SHALL have port busy, output, NCH: per-channel busy flags.
REQ-018 SHALL have port irq, output, 1: level interrupt.

Function
REQ-019 Register offsets SHALL be: 0..NP-1 PARAM; 0x10 START; 0x11 STATUS {29'b0, err, done, busy}; 0x12 TIME; 0x13 CLEAR; 0x14 IRQ_EN (bit0); 0x1F CHECK, read-only, 32'hF0F0F0F0 for any channel field.
REQ-020 A write SHALL occur when config_ena && config_wr and take effect at the next clk edge.
REQ-021 PARAM writes to a busy channel SHALL be dropped and set that channel's err.
REQ-022 START write with wdata[0]=1 to an idle channel SHALL, next cycle, set busy, clear TIME to 0, and drive core_start[ch]=1 for exactly one cycle.
REQ-023 START write to a busy channel SHALL be ignored (no pulse) and set err; wdata[0]=0 SHALL be a no-op.
REQ-024 Each busy channel SHALL contain a 2-state machine, IDLE->BUSY on accepted START and BUSY->IDLE on core_done[ch].
REQ-025 core_done[ch] in BUSY SHALL clear busy and set sticky done next cycle; core_done while IDLE SHALL be ignored.
REQ-026 TIME SHALL increment every cycle busy is 1, saturate at 32'hFFFFFFFF, and hold when idle.
REQ-027 CLEAR write SHALL clear done if wdata[0]=1 and err if wdata[1]=1; a set event in the same cycle SHALL win over the clear.
REQ-028 A read (config_ena && !config_wr) SHALL return data in config_rdata with config_rvalid=1 exactly one cycle later; otherwise rvalid=0 and rdata SHALL hold.
REQ-029 Reads of unmapped offsets, or of channel field >= NCH (CHECK excepted), SHALL return 0; writes to them SHALL be ignored.
REQ-030 irq SHALL be the registered OR over channels of (done & irq_en).
REQ-031 Channels SHALL operate independently; concurrent events on different channels SHALL all take effect.

Reset
REQ-032 rst SHALL asynchronously zero all PARAM, TIME, busy, done, err, irq_en, core_start, config_rdata, config_rvalid and irq.
REQ-033 rst asserted mid-BUSY SHALL return the channel to IDLE with no core_start pulse after release.

Structure
REQ-034 Register offsets, the CHECK constant and the STATUS bit positions SHALL live in shared package accel_cfg_pkg.
REQ-035 Per-channel registers, the FSM and TIME SHALL be in sub-module cfg_channel, instantiated NCH times; read muxing SHALL be in the top level.

Verification
REQ-036 Write PARAM1 of ch2 = 0xDEADBEEF, then read it -> rvalid one cycle later with 0xDEADBEEF, and param_flat[(2*NP+1)*DW +: DW] = 0xDEADBEEF.
REQ-037 START ch0; core_done[0] 10 cycles after core_start -> single start pulse, STATUS = 0x2, TIME = 10.
REQ-038 START ch1 while busy, plus a PARAM write -> no second pulse, err=1, PARAM unchanged; CLEAR 0x2 -> err=0.
REQ-039 IRQ_EN ch3 = 1, complete ch3 -> irq=1; CLEAR 0x1 in the same cycle as a new done -> done stays 1.
REQ-040 Force TIME near 32'hFFFFFFFF via a long busy period (or a small-width build) -> TIME saturates; rst mid-BUSY -> all outputs 0, CHECK still reads 32'hF0F0F0F0.
